// File: rtl/ready_counter.sv
// Programmable interval counter: one-cycle ready_o pulse every (interrupt_num_i + 1) enabled cycles.
// Optional macro READY_COUNTER_PULSE_CNT_EN adds a saturating 16-bit pulse counter output.
module ready_counter #(
   parameter int WIDTH_CNT = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en_i,
   input  logic [WIDTH_CNT-1:0] interrupt_num_i,
   output logic                 ready_o
`ifdef READY_COUNTER_PULSE_CNT_EN
   ,
   output logic [15:0]          pulse_cnt_o
`endif
);

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_t;

   localparam logic [WIDTH_CNT-1:0] CNT_ONE = WIDTH_CNT'(1);

   state_t               state_reg, state_next;
   logic [WIDTH_CNT-1:0] cnt_reg, cnt_next;
   logic [WIDTH_CNT-1:0] term_reg, term_next;
   logic                 ready_reg, ready_next;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         term_reg  <= '0;
         ready_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         term_reg  <= term_next;
         ready_reg <= ready_next;
      end
   end

   // The wrap is decided by the latched terminal, so cnt never runs past term.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      term_next  = term_reg;
      ready_next = 1'b0;
      case (state_reg)
         IDLE: begin
            cnt_next = '0;
            if (en_i) begin
               term_next  = interrupt_num_i;
               state_next = COUNT;
            end
         end
         COUNT: begin
            if (en_i) begin
               if (cnt_reg == term_reg) begin
                  cnt_next   = '0;
                  ready_next = 1'b1;
                  term_next  = interrupt_num_i;
               end else begin
                  cnt_next = cnt_reg + CNT_ONE;
               end
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   assign ready_o = ready_reg;

`ifdef READY_COUNTER_PULSE_CNT_EN
   logic [15:0] pulse_cnt_reg, pulse_cnt_next;

   // Saturates rather than wraps so software can detect overflow.
   always_comb begin
      pulse_cnt_next = pulse_cnt_reg;
      if (ready_next && (pulse_cnt_reg != 16'hFFFF)) begin
         pulse_cnt_next = pulse_cnt_reg + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pulse_cnt_reg <= '0;
      end else begin
         pulse_cnt_reg <= pulse_cnt_next;
      end
   end

   assign pulse_cnt_o = pulse_cnt_reg;
`endif

endmodule

// File: tb/tb_ready_counter.sv
// Directed bench for ready_counter: a countdown model pushes expected outputs per edge,
// which are popped and compared after the edge.
module tb_ready_counter;
   localparam int W = 5;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         en_i = 1'b0;
   logic [W-1:0] interrupt_num_i = '0;
   logic         ready_o;
`ifdef READY_COUNTER_PULSE_CNT_EN
   logic [15:0]  pulse_cnt_o;
`endif

   int checks = 0;
   int failures = 0;
   bit          exp_q[$];
   int unsigned exp_pc_q[$];

   // Reference state: edges remaining until the next pulse, reloaded at each wrap.
   bit          m_active = 1'b0;
   int          m_remaining = 0;
   int unsigned m_pulses = 0;
   int          pulses_seen = 0;
   int          n;

   always #5 clk = ~clk;

   ready_counter #(.WIDTH_CNT(W)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .en_i            (en_i),
      .interrupt_num_i (interrupt_num_i),
      .ready_o         (ready_o)
`ifdef READY_COUNTER_PULSE_CNT_EN
      ,
      .pulse_cnt_o     (pulse_cnt_o)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      bit e;
      bit got;
      int unsigned pc;
      e = 1'b0;
      if (!rst_n) begin
         m_active = 1'b0;
         m_pulses = 0;
      end else if (!m_active) begin
         if (en_i) begin
            m_active    = 1'b1;
            m_remaining = int'(interrupt_num_i) + 1;
         end
      end else if (en_i) begin
         m_remaining--;
         if (m_remaining == 0) begin
            e           = 1'b1;
            m_remaining = int'(interrupt_num_i) + 1;
            if (m_pulses != 32'd65535) m_pulses++;
         end
      end
      exp_q.push_back(e);
      exp_pc_q.push_back(m_pulses);
      @(posedge clk);
      #1;
      got = exp_q.pop_front();
      check("ready_o", {31'd0, ready_o}, {31'd0, got});
      if (ready_o === 1'b1) pulses_seen++;
      pc = exp_pc_q.pop_front();
`ifdef READY_COUNTER_PULSE_CNT_EN
      check("pulse_cnt_o", {16'd0, pulse_cnt_o}, pc);
`endif
   endtask

   // Ticks until ready_o pulses (bounded); returns the number of edges taken.
   task automatic wait_pulse(input string tag, input int max_edges, output int edges);
      edges = 0;
      for (int i = 0; i < max_edges; i++) begin
         tick();
         edges++;
         if (ready_o === 1'b1) break;
      end
      check(tag, {31'd0, ready_o}, 32'd1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      en_i  = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      // Reset held with enable asserted: no pulse may escape.
      rst_n = 1'b0;
      en_i = 1'b1;
      interrupt_num_i = 5'd2;
      pulses_seen = 0;
      repeat (10) tick();
      check("reset_no_pulse", pulses_seen, 0);

      // Nominal period of 3 over 1000 enabled edges; entry edge counts as edge 1.
      rst_n = 1'b1;
      pulses_seen = 0;
      wait_pulse("nominal_first", 10, n);
      check("nominal_first_latency", n, 4);
      repeat (1000 - n) tick();
      check("nominal_pulse_total", ((pulses_seen >= 332) && (pulses_seen <= 334)) ? 32'd1 : 32'd0, 32'd1);
      wait_pulse("nominal_gap", 10, n);
      check("nominal_gap_len", n, 3);

      // Pause at cnt=2 with term=4: edges to pulse after resume = 4 - 2 + 1.
      do_reset();
      interrupt_num_i = 5'd4;
      en_i = 1'b1;
      repeat (3) tick();
      en_i = 1'b0;
      pulses_seen = 0;
      repeat (7) tick();
      check("pause_no_pulse", pulses_seen, 0);
      en_i = 1'b1;
      wait_pulse("pause_resume", 10, n);
      check("pause_resume_latency", n, 3);

      // Terminal zero: high on every enabled edge after IDLE exit, low while paused.
      do_reset();
      interrupt_num_i = 5'd0;
      en_i = 1'b1;
      tick();
      pulses_seen = 0;
      repeat (20) tick();
      check("term0_continuous", pulses_seen, 20);
      en_i = 1'b0;
      pulses_seen = 0;
      repeat (3) tick();
      check("term0_paused", pulses_seen, 0);

      // Terminal max: full 32-cycle period.
      do_reset();
      interrupt_num_i = 5'd31;
      en_i = 1'b1;
      tick();
      wait_pulse("term31_first", 40, n);
      check("term31_first_len", n, 32);
      wait_pulse("term31_second", 40, n);
      check("term31_period", n, 32);

      // Mid-period change 5 -> 1 at cnt=2: current period completes, then period 2.
      do_reset();
      interrupt_num_i = 5'd5;
      en_i = 1'b1;
      repeat (3) tick();
      interrupt_num_i = 5'd1;
      wait_pulse("change_finish", 10, n);
      check("change_finish_len", n, 4);
      wait_pulse("change_new1", 10, n);
      check("change_new_period1", n, 2);
      wait_pulse("change_new2", 10, n);
      check("change_new_period2", n, 2);

      // Reset for one edge at cnt=3 (term=5): progress discarded, restart from IDLE entry.
      do_reset();
      interrupt_num_i = 5'd5;
      en_i = 1'b1;
      repeat (4) tick();
      rst_n = 1'b0;
      pulses_seen = 0;
      tick();
      check("midreset_no_pulse", pulses_seen, 0);
      rst_n = 1'b1;
      wait_pulse("midreset_restart", 20, n);
      check("midreset_restart_latency", n, 7);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
